// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (req 0) and the branch unit (req 1).
// Invalid opcodes and ALU operations that never complete are answered locally with rsp_err.
module alu_req_arbiter #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  soc_clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_accept,
    input  logic [9:0]            req_instr,
    input  logic [2*DATA_W-1:0]   req_dat1,
    input  logic [2*DATA_W-1:0]   req_dat2,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_out,
    output logic                  rsp_overflow,
    output logic                  rsp_zero,
    output logic                  rsp_con_met,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  dat_ready,
    output logic [DATA_W-1:0]     ALU_dat1,
    output logic [DATA_W-1:0]     ALU_dat2,
    output logic [4:0]            Instruction_to_ALU,
    input  logic                  ALU_ready,
    input  logic                  ALU_err,
    input  logic                  ALU_overflow,
    input  logic                  ALU_zero,
    input  logic                  ALU_con_met,
    input  logic [DATA_W-1:0]     ALU_out
);

    // state | meaning: IDLE arbitrate | ISSUE first operand cycle | WAIT await ALU_ready
    //       | RESP pulse rsp_valid to owner | RELEASE wait for ALU_ready to drop
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_RELEASE
    } state_t;

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [4:0]       INSTR_NONE = 5'd16;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_dat1_q, alu_dat1_d;
    logic [DATA_W-1:0]   alu_dat2_q, alu_dat2_d;
    logic [4:0]          instr_q, instr_d;
    logic [DATA_W-1:0]   rsp_out_q, rsp_out_d;
    logic                rsp_ovf_q, rsp_ovf_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_con_q, rsp_con_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_to_q, rsp_to_d;

    logic                any_valid;
    logic                grant;
    logic [4:0]          sel_instr;
    logic [DATA_W-1:0]   sel_dat1;
    logic [DATA_W-1:0]   sel_dat2;

    // With both requesting, the one not granted last wins; otherwise the lone requester.
    assign any_valid = |req_valid;
    assign grant     = (&req_valid) ? ~rr_q : req_valid[1];
    assign sel_instr = grant ? req_instr[9:5] : req_instr[4:0];
    assign sel_dat1  = grant ? req_dat1[2*DATA_W-1:DATA_W] : req_dat1[DATA_W-1:0];
    assign sel_dat2  = grant ? req_dat2[2*DATA_W-1:DATA_W] : req_dat2[DATA_W-1:0];

    assign req_accept[0] = (state_q == S_IDLE) && req_valid[0] && !grant;
    assign req_accept[1] = (state_q == S_IDLE) && req_valid[1] && grant;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        alu_dat1_d = alu_dat1_q;
        alu_dat2_d = alu_dat2_q;
        instr_d    = instr_q;
        rsp_out_d  = rsp_out_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_zero_d = rsp_zero_q;
        rsp_con_d  = rsp_con_q;
        rsp_err_d  = rsp_err_q;
        rsp_to_d   = rsp_to_q;

        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    owner_d = grant;
                    rr_d    = grant;
                    if (sel_instr[4]) begin
                        rsp_out_d  = '0;
                        rsp_ovf_d  = 1'b0;
                        rsp_zero_d = 1'b0;
                        rsp_con_d  = 1'b0;
                        rsp_err_d  = 1'b1;
                        rsp_to_d   = 1'b0;
                        state_d    = S_RESP;
                    end else begin
                        instr_d    = sel_instr;
                        alu_dat1_d = sel_dat1;
                        alu_dat2_d = sel_dat2;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ALU_ready) begin
                    rsp_out_d  = ALU_out;
                    rsp_ovf_d  = ALU_overflow;
                    rsp_zero_d = ALU_zero;
                    rsp_con_d  = ALU_con_met;
                    rsp_err_d  = ALU_err;
                    rsp_to_d   = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == '0) begin
                    rsp_out_d  = '0;
                    rsp_ovf_d  = 1'b0;
                    rsp_zero_d = 1'b0;
                    rsp_con_d  = 1'b0;
                    rsp_err_d  = 1'b1;
                    rsp_to_d   = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RESP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // A stuck-high ALU_ready must not lock the arbiter out forever.
                if (!ALU_ready || (cnt_q == '0)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            alu_dat1_q <= '0;
            alu_dat2_q <= '0;
            instr_q    <= INSTR_NONE;
            rsp_out_q  <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_con_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            alu_dat1_q <= alu_dat1_d;
            alu_dat2_q <= alu_dat2_d;
            instr_q    <= instr_d;
            rsp_out_q  <= rsp_out_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_con_q  <= rsp_con_d;
            rsp_err_q  <= rsp_err_d;
            rsp_to_q   <= rsp_to_d;
        end
    end

    assign dat_ready          = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign rsp_valid          = (state_q == S_RESP) ? {owner_q, ~owner_q} : 2'b00;
    assign ALU_dat1           = alu_dat1_q;
    assign ALU_dat2           = alu_dat2_q;
    assign Instruction_to_ALU = instr_q;
    assign rsp_out            = rsp_out_q;
    assign rsp_overflow       = rsp_ovf_q;
    assign rsp_zero           = rsp_zero_q;
    assign rsp_con_met        = rsp_con_q;
    assign rsp_err            = rsp_err_q;
    assign rsp_timeout        = rsp_to_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level timing model and a behavioural ALU stub.
module tb_alu_req_arbiter;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic          err;
        logic          con;
        logic          ovf;
        logic          zero;
        logic [DW-1:0] out;
    } res_t;

    typedef struct {
        logic [4:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;   // 0: ALU never answers
        int            hold;  // extra cycles ALU_ready stays high after the answer
    } req_t;

    logic soc_clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_accept;
    logic [9:0] req_instr = '0;
    logic [2*DW-1:0] req_dat1 = '0;
    logic [2*DW-1:0] req_dat2 = '0;
    logic [1:0] rsp_valid;
    logic [DW-1:0] rsp_out;
    logic rsp_overflow, rsp_zero, rsp_con_met, rsp_err, rsp_timeout;
    logic dat_ready;
    logic [DW-1:0] ALU_dat1, ALU_dat2;
    logic [4:0] Instruction_to_ALU;
    logic ALU_ready = 1'b0;
    logic ALU_err, ALU_overflow, ALU_zero, ALU_con_met;
    logic [DW-1:0] ALU_out;

    always #5 soc_clk = ~soc_clk;

    alu_req_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .soc_clk(soc_clk), .reset(reset),
        .req_valid(req_valid), .req_accept(req_accept), .req_instr(req_instr),
        .req_dat1(req_dat1), .req_dat2(req_dat2),
        .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_overflow(rsp_overflow),
        .rsp_zero(rsp_zero), .rsp_con_met(rsp_con_met), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .dat_ready(dat_ready),
        .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2), .Instruction_to_ALU(Instruction_to_ALU),
        .ALU_ready(ALU_ready), .ALU_err(ALU_err), .ALU_overflow(ALU_overflow),
        .ALU_zero(ALU_zero), .ALU_con_met(ALU_con_met), .ALU_out(ALU_out)
    );

    function automatic res_t alu_fn(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        res_t r;
        r = '0;
        case (op)
            5'd0:  r.con = (a == b);
            5'd1:  r.con = (a != b);
            5'd2:  r.con = ($signed(a) < $signed(b));
            5'd3:  r.con = ($signed(a) >= $signed(b));
            5'd4:  r.con = (a < b);
            5'd5:  r.con = (a >= b);
            5'd6:  begin r.out = a + b; r.ovf = (a[DW-1] == b[DW-1]) && (r.out[DW-1] != a[DW-1]); end
            5'd7:  begin r.out = a - b; r.ovf = (a[DW-1] != b[DW-1]) && (r.out[DW-1] != a[DW-1]); end
            5'd8:  r.out = a & b;
            5'd9:  r.out = a | b;
            5'd10: r.out = a << b[4:0];
            5'd11: r.out = a ^ b;
            5'd12: r.out = a >> b[4:0];
            5'd13: r.out = $signed(a) >>> b[4:0];
            5'd14: r.out = ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            5'd15: begin if (b == '0) r.err = 1'b1; else r.out = a / b; end
            default: r = '0;
        endcase
        if (op >= 5'd6 && op <= 5'd15) r.zero = (r.out == '0);
        return r;
    endfunction

    // ALU stub: answers from whatever operands the arbiter presents
    res_t alu_now;
    always_comb alu_now = alu_fn(Instruction_to_ALU, ALU_dat1, ALU_dat2);
    assign ALU_out      = alu_now.out;
    assign ALU_err      = alu_now.err;
    assign ALU_overflow = alu_now.ovf;
    assign ALU_zero     = alu_now.zero;
    assign ALU_con_met  = alu_now.con;

    int t = 0;
    always @(posedge soc_clk) t <= t + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, t);
        end
    endtask

    // transaction-level model state
    req_t dq0[$];
    req_t dq1[$];
    req_t pend[2];
    bit   pend_v[2];
    bit   rand_en = 1'b0;
    bit   rst_req = 1'b1;
    int   rst_edge = -10;
    int   last_g = 1;
    int   free_edge = 0;
    bit   op_act = 1'b0;
    bit   op_inv;
    int   op_N, op_R, op_lo, op_hi, op_owner;
    req_t op_req;
    res_t op_exp;
    bit   op_to;
    res_t h_res = '0;
    bit   h_to = 1'b0;

    function automatic req_t mk(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input int lat, input int hold);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.lat = lat; r.hold = hold;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int k;
        r.op = ($urandom_range(0, 9) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
        r.a  = $urandom;
        r.b  = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom);
        r.lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 17));
        k = int'($urandom_range(0, 19));
        r.hold = (k == 0) ? 17 : (k < 4) ? int'($urandom_range(1, 5)) : 0;
        return r;
    endfunction

    task automatic accept_op(input int g);
        int rel;
        op_act   = 1'b1;
        op_N     = t + 1;
        op_owner = g;
        op_req   = pend[g];
        pend_v[g] = 1'b0;
        last_g   = g;
        op_inv   = op_req.op >= 5'd16;
        op_to    = 1'b0;
        op_lo    = 1;
        op_hi    = 0;
        op_exp   = '0;
        if (op_inv) begin
            op_R = op_N;
            op_exp.err = 1'b1;
            op_req.hold = 0;
        end else if (op_req.lat == 0) begin
            op_R = op_N + TO + 1;
            op_exp.err = 1'b1;
            op_to = 1'b1;
            op_req.hold = 0;
        end else begin
            op_R  = op_N + ((op_req.lat < 2) ? 2 : op_req.lat);
            op_lo = op_N + op_req.lat - 1;
            op_hi = op_R + op_req.hold - 1;
            op_exp = alu_fn(op_req.op, op_req.a, op_req.b);
        end
        rel = op_R + 2;
        if (op_R + op_req.hold + 1 > rel) rel = op_R + op_req.hold + 1;
        if (rel > op_R + TO + 1) rel = op_R + TO + 1;
        free_edge = rel + 1;
    endtask

    task automatic step();
        logic [1:0] e_acc, e_rv;
        logic e_dr;
        int g;
        bit can;
        @(negedge soc_clk);
        e_dr = op_act && !op_inv && (t >= op_N) && (t < op_R);
        e_rv = 2'b00;
        if (op_act && t == op_R) begin
            e_rv = (op_owner == 1) ? 2'b10 : 2'b01;
            h_res = op_exp;
            h_to  = op_to;
        end

        reset = rst_req;
        for (int i = 0; i < 2; i++) begin
            if (pend_v[i] && rand_en && $urandom_range(0, 19) == 0) begin
                pend_v[i] = 1'b0;
            end else if (!pend_v[i]) begin
                if (i == 0 && dq0.size() > 0) begin
                    pend[0] = dq0.pop_front(); pend_v[0] = 1'b1;
                end else if (i == 1 && dq1.size() > 0) begin
                    pend[1] = dq1.pop_front(); pend_v[1] = 1'b1;
                end else if (rand_en && $urandom_range(0, 2) == 0) begin
                    pend[i] = rand_req(); pend_v[i] = 1'b1;
                end
            end
        end
        req_valid = {pend_v[1], pend_v[0]};
        req_instr = {pend[1].op, pend[0].op};
        req_dat1  = {pend[1].a, pend[0].a};
        req_dat2  = {pend[1].b, pend[0].b};
        ALU_ready = op_act && !op_inv && (op_lo <= op_hi) && (t >= op_lo) && (t <= op_hi);

        g   = (pend_v[0] && pend_v[1]) ? 1 - last_g : (pend_v[1] ? 1 : 0);
        can = (t + 1 >= free_edge) && (pend_v[0] || pend_v[1]);
        e_acc = can ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
        #1;
        check_val("req_accept", 64'(req_accept), 64'(e_acc));
        check_val("dat_ready", 64'(dat_ready), 64'(e_dr));
        check_val("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        check_val("rsp_out", 64'(rsp_out), 64'(h_res.out));
        check_val("rsp_overflow", 64'(rsp_overflow), 64'(h_res.ovf));
        check_val("rsp_zero", 64'(rsp_zero), 64'(h_res.zero));
        check_val("rsp_con_met", 64'(rsp_con_met), 64'(h_res.con));
        check_val("rsp_err", 64'(rsp_err), 64'(h_res.err));
        check_val("rsp_timeout", 64'(rsp_timeout), 64'(h_to));
        if (e_dr) begin
            check_val("alu_instr", 64'(Instruction_to_ALU), 64'(op_req.op));
            check_val("alu_dat1", 64'(ALU_dat1), 64'(op_req.a));
            check_val("alu_dat2", 64'(ALU_dat2), 64'(op_req.b));
        end
        if (t == rst_edge) begin
            check_val("rst_instr", 64'(Instruction_to_ALU), 64'd16);
            check_val("rst_dat1", 64'(ALU_dat1), 64'd0);
            check_val("rst_dat2", 64'(ALU_dat2), 64'd0);
        end

        if (rst_req) begin
            op_act    = 1'b0;
            last_g    = 1;
            free_edge = t + 2;
            h_res     = '0;
            h_to      = 1'b0;
            rst_edge  = t + 1;
        end else if (can) begin
            accept_op(g);
        end
    endtask

    function automatic bit busy();
        return (dq0.size() > 0) || (dq1.size() > 0) || pend_v[0] || pend_v[1] || (t + 1 < free_edge);
    endfunction

    task automatic drain(input int max_cycles);
        for (int k = 0; k < max_cycles && busy(); k++) step();
        check_val("drain_bound", 64'(busy()), 64'd0);
    endtask

    initial begin
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        pend[0] = mk(5'd0, '0, '0, 1, 0);
        pend[1] = mk(5'd0, '0, '0, 1, 0);
        step();
        step();
        rst_req = 1'b0;

        // both held: grants alternate 0,1,0,1
        dq0.push_back(mk(5'd7, 32'd5, 32'd3, 3, 0));
        dq0.push_back(mk(5'd7, 32'd5, 32'd3, 2, 1));
        dq1.push_back(mk(5'd11, 32'h0F0F0F0F, 32'hFF00FF00, 4, 0));
        dq1.push_back(mk(5'd11, 32'h0F0F0F0F, 32'hFF00FF00, 1, 3));
        drain(300);

        dq0.push_back(mk(5'd6, 32'd5, 32'd3, 4, 0));
        drain(100);
        dq1.push_back(mk(5'd0, 32'd5, 32'd5, 2, 0));
        drain(100);
        dq0.push_back(mk(5'd16, 32'd9, 32'd9, 3, 0));
        drain(100);
        dq0.push_back(mk(5'd6, 32'd1, 32'd2, 0, 0));
        drain(100);
        dq1.push_back(mk(5'd9, 32'hA0, 32'h0B, 3, 17));
        drain(100);
        dq0.push_back(mk(5'd6, 32'h7FFFFFFF, 32'd1, 17, 0));
        drain(100);

        // reset pulsed while an op sits in WAIT
        dq0.push_back(mk(5'd6, 32'd7, 32'd8, 0, 0));
        for (int k = 0; k < 100 && !(op_act && t >= op_N + 4); k++) step();
        check_val("reach_wait", 64'(op_act && t >= op_N + 4), 64'd1);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        dq0.push_back(mk(5'd6, 32'd5, 32'd3, 3, 0));
        drain(100);

        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        drain(200);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
